// File: rtl/ex_muldiv_unit_pkg.sv
// Shared RV32M definitions: func3 encodings, FSM state codes and architectural constants.
package rv32m_pkg;
  localparam int XLEN  = 32;
  localparam int STEPS = 32;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;
endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage handshake between the ID/EX pipeline control and the mul/div unit.
interface ex_muldiv_unit_if;
  logic        START;
  logic        FLUSH;
  logic        STALL_IN;
  logic [2:0]  FUNC3;
  logic [31:0] OPERAND_A;
  logic [31:0] OPERAND_B;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  modport master (output START, FLUSH, STALL_IN, FUNC3, OPERAND_A, OPERAND_B,
                  input  BUSY, DONE, RESULT);
  modport slave  (input  START, FLUSH, STALL_IN, FUNC3, OPERAND_A, OPERAND_B,
                  output BUSY, DONE, RESULT);
endinterface

// File: rtl/ex_muldiv_unit_sign_adjust.sv
// Sign handling for the mul/div unit: operand magnitudes and result sign on entry,
// negation and word selection of the final product/quotient/remainder on exit.
module muldiv_sign_adjust
  import rv32m_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] mag_a,
  output logic [31:0] mag_b,
  output logic        ent_neg,
  input  logic [63:0] fin_acc,
  input  logic [32:0] fin_rem,
  input  logic        fin_neg,
  output logic [31:0] result
);
  logic        sgn_a, sgn_b, neg_a, neg_b;
  logic [63:0] sel, adj;

  always_comb begin
    sgn_a   = func3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    sgn_b   = func3 inside {F3_MULH, F3_DIV, F3_REM};
    neg_a   = sgn_a & op_a[31];
    neg_b   = sgn_b & op_b[31];
    mag_a   = neg_a ? -op_a : op_a;
    mag_b   = neg_b ? -op_b : op_b;
    // MULHSU and REM take their sign from the dividend/multiplicand alone
    ent_neg = (func3 == F3_MULHSU || func3 == F3_REM) ? neg_a : (neg_a ^ neg_b);
    sel     = (func3 inside {F3_REM, F3_REMU}) ? {31'b0, fin_rem} : fin_acc;
    adj     = fin_neg ? -sel : sel;
    result  = (func3 == F3_MUL || func3[2]) ? adj[31:0] : adj[63:32];
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit (32 steps). Define MULDIV_FAST_MUL_EN for a
// single-cycle multiplier; divides stay iterative either way.
module ex_muldiv_unit
  import rv32m_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET_N,
  ex_muldiv_unit_if.slave bus
);
  state_t            state;
  logic [4:0]        count;
  logic [2:0]        f3;
  logic              neg;
  logic [XLEN-1:0]   opb, rem, result_q;
  logic [2*XLEN-1:0] acc;

  logic accept;
  assign accept     = (state == ST_IDLE) && bus.START && !bus.FLUSH;
  assign bus.BUSY   = accept || (state == ST_CALC);
  assign bus.DONE   = (state == ST_DONE);
  assign bus.RESULT = result_q;

  // one step: shift-add multiply in acc, or restoring divide with quotient in acc[31:0]
  logic [XLEN:0]     msum, r_sh, diff, rem_next;
  logic              ge;
  logic [2*XLEN-1:0] acc_next;
  always_comb begin
    msum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    r_sh     = {rem, acc[31]};
    ge       = r_sh >= {1'b0, opb};
    diff     = r_sh - {1'b0, opb};
    rem_next = ge ? diff : r_sh;
    acc_next = f3[2] ? {32'b0, acc[30:0], ge} : {msum, acc[31:1]};
  end

  logic [2:0]  sa_f3;
  logic [31:0] mag_a, mag_b, fin_res;
  logic        ent_neg;
  assign sa_f3 = (state == ST_IDLE) ? bus.FUNC3 : f3;

  muldiv_sign_adjust u_sadj (
    .func3   (sa_f3),
    .op_a    (bus.OPERAND_A),
    .op_b    (bus.OPERAND_B),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .ent_neg (ent_neg),
    .fin_acc (acc_next),
    .fin_rem (rem_next),
    .fin_neg (neg),
    .result  (fin_res)
  );

  logic        div0, ovf;
  logic [31:0] spec_res;
  always_comb begin
    div0     = bus.FUNC3[2] && (bus.OPERAND_B == '0);
    ovf      = bus.FUNC3[2] && !bus.FUNC3[0] &&
               (bus.OPERAND_A == INT_MIN) && (bus.OPERAND_B == '1);
    spec_res = '0;
    if (div0)     spec_res = bus.FUNC3[1] ? bus.OPERAND_A : DIV0_QUOT;
    else if (ovf) spec_res = bus.FUNC3[1] ? 32'd0 : INT_MIN;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [32:0] fa, fb;
  logic signed [63:0] fp;
  logic               fast;
  logic [31:0]        fast_res;
  always_comb begin
    fa       = {(bus.FUNC3 != F3_MULHU) & bus.OPERAND_A[31], bus.OPERAND_A};
    fb       = {((bus.FUNC3 == F3_MUL) || (bus.FUNC3 == F3_MULH)) & bus.OPERAND_B[31],
                bus.OPERAND_B};
    fp       = fa * fb;
    fast     = !bus.FUNC3[2];
    fast_res = (bus.FUNC3 == F3_MUL) ? fp[31:0] : fp[63:32];
  end
`else
  logic        fast;
  logic [31:0] fast_res;
  assign fast     = 1'b0;
  assign fast_res = '0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= ST_IDLE;
      count    <= '0;
      f3       <= '0;
      neg      <= 1'b0;
      opb      <= '0;
      rem      <= '0;
      acc      <= '0;
      result_q <= '0;
    end else if (bus.FLUSH) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.START) begin
          f3    <= bus.FUNC3;
          neg   <= ent_neg;
          count <= '0;
          if (div0 || ovf) begin
            result_q <= spec_res;
            state    <= ST_DONE;
          end else if (fast) begin
            result_q <= fast_res;
            state    <= ST_DONE;
          end else begin
            state <= ST_CALC;
            rem   <= '0;
            opb   <= bus.FUNC3[2] ? mag_b : mag_a;
            acc   <= {32'b0, bus.FUNC3[2] ? mag_a : mag_b};
          end
        end
        ST_CALC: begin
          acc   <= acc_next;
          rem   <= rem_next[31:0];
          count <= count + 5'd1;
          if (count == 5'(STEPS - 1)) begin
            result_q <= fin_res;
            state    <= ST_DONE;
          end
        end
        // waiting in DONE keeps a held START from being taken twice
        ST_DONE: if (!bus.STALL_IN) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized self-checking bench for ex_muldiv_unit against an arithmetic reference model.
module tb_ex_muldiv_unit;
  import rv32m_pkg::*;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  ex_muldiv_unit_if bus ();
  ex_muldiv_unit dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus));

  always #5 CLK = ~CLK;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] last_exp = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub, p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2]) begin
      if (b == 0) return 1;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] got);
    logic [31:0] exp;
    int lat, nbusy;
    exp = ref_op(f, a, b);
    @(posedge CLK); #1;
    bus.START = 1'b1; bus.FUNC3 = f; bus.OPERAND_A = a; bus.OPERAND_B = b;
    lat = 0; nbusy = 0;
    @(negedge CLK);
    while (!bus.DONE && lat < 100) begin
      if (bus.BUSY) nbusy++;
      @(posedge CLK); lat++;
      @(negedge CLK);
    end
    check("latency", 32'(lat), 32'(ref_lat(f, a, b)));
    check("busy_cycles", 32'(nbusy), 32'(ref_lat(f, a, b)));
    check("busy_at_done", 32'(bus.BUSY), 32'd0);
    check($sformatf("result f3=%0d a=%h b=%h", f, a, b), bus.RESULT, exp);
    got = bus.RESULT;
    last_exp = exp;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    @(negedge CLK);
    check("done_drops", 32'(bus.DONE), 32'd0);
  endtask

  logic [2:0]  d_f3 [11] = '{F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU, F3_DIV, F3_REM,
                              F3_DIVU, F3_REMU, F3_DIVU, F3_REM, F3_DIV};
  logic [31:0] d_a  [11] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000};
  logic [31:0] d_b  [11] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                              32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF};
  logic [31:0] d_r  [11] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
                              32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int lat, ndone;
    bus.START = 1'b0; bus.FLUSH = 1'b0; bus.STALL_IN = 1'b0;
    bus.FUNC3 = '0; bus.OPERAND_A = '0; bus.OPERAND_B = '0;
    #12;
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_done", 32'(bus.DONE), 32'd0);
    check("rst_result", bus.RESULT, 32'd0);
    @(negedge CLK) RESET_N = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(d_f3[i], d_a[i], d_b[i], got);
      check($sformatf("plan%0d", i), got, d_r[i]);
    end

    for (int i = 0; i < 40; i++) begin
      logic [2:0] f;
      f = 3'($urandom_range(0, 7));
      run_op(f, pick(), pick(), got);
    end

    // stall held over DONE with START still asserted
    @(posedge CLK); #1;
    bus.STALL_IN = 1'b1; bus.START = 1'b1; bus.FUNC3 = F3_MUL;
    bus.OPERAND_A = 32'd7; bus.OPERAND_B = 32'hFFFF_FFFD;
    lat = 0;
    @(negedge CLK);
    while (!bus.DONE && lat < 100) begin @(posedge CLK); lat++; @(negedge CLK); end
    check("stall_lat", 32'(lat), 32'(ref_lat(F3_MUL, 32'd7, 32'hFFFF_FFFD)));
    ndone = 1;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); @(negedge CLK);
      if (bus.DONE) ndone++;
      check("stall_no_rerun", 32'(bus.BUSY), 32'd0);
      check("stall_hold", bus.RESULT, 32'hFFFF_FFEB);
    end
    @(posedge CLK); #1 bus.STALL_IN = 1'b0;
    @(negedge CLK);
    if (bus.DONE) ndone++;
    check("stall_hold4", bus.RESULT, 32'hFFFF_FFEB);
    check("stall_done_cycles", 32'(ndone), 32'd4);
    @(posedge CLK); #1 bus.START = 1'b0;
    @(negedge CLK);
    check("stall_exit_done", 32'(bus.DONE), 32'd0);
    check("stall_exit_busy", 32'(bus.BUSY), 32'd0);
    last_exp = 32'hFFFF_FFEB;

    // flush during a divide
    @(posedge CLK); #1;
    bus.START = 1'b1; bus.FUNC3 = F3_DIV; bus.OPERAND_A = 32'd1000; bus.OPERAND_B = 32'd7;
    repeat (10) @(posedge CLK);
    #1 bus.FLUSH = 1'b1;
    @(posedge CLK); #1 begin bus.FLUSH = 1'b0; bus.START = 1'b0; end
    @(negedge CLK);
    check("flush_busy", 32'(bus.BUSY), 32'd0);
    check("flush_result", bus.RESULT, last_exp);
    ndone = 0;
    repeat (40) begin @(posedge CLK); @(negedge CLK); if (bus.DONE) ndone++; end
    check("flush_no_done", 32'(ndone), 32'd0);
    run_op(F3_DIVU, 32'd9, 32'd3, got);
    check("after_flush", got, 32'd3);

    // asynchronous reset mid-divide
    @(posedge CLK); #1;
    bus.START = 1'b1; bus.FUNC3 = F3_DIV; bus.OPERAND_A = 32'd1000; bus.OPERAND_B = 32'd7;
    repeat (20) @(posedge CLK);
    #1 begin RESET_N = 1'b0; bus.START = 1'b0; end
    #1;
    check("arst_busy", 32'(bus.BUSY), 32'd0);
    check("arst_done", 32'(bus.DONE), 32'd0);
    check("arst_result", bus.RESULT, 32'd0);
    @(negedge CLK) RESET_N = 1'b1;
    @(negedge CLK);
    check("arst_idle", 32'(bus.BUSY), 32'd0);
    run_op(F3_DIVU, 32'd9, 32'd3, got);
    check("after_reset", got, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
